// File: rtl/traffic_pkg.sv
// Shared types for the two-approach traffic controller: state codes, direction,
// and the Moore lamp decode.
package traffic_pkg;

    typedef enum logic [2:0] {
        StNsG  = 3'd0,
        StNsY  = 3'd1,
        StArNe = 3'd2,
        StEwG  = 3'd3,
        StEwY  = 3'd4,
        StArEn = 3'd5,
        StWalk = 3'd6
    } state_e;

    typedef enum logic {
        DirNs = 1'b0,
        DirEw = 1'b1
    } dir_e;

    typedef struct packed {
        logic ns_green;
        logic ns_yellow;
        logic ns_red;
        logic ew_green;
        logic ew_yellow;
        logic ew_red;
        logic ped_walk;
    } lamps_t;

    // Anything not explicitly green/yellow shows red on both approaches.
    function automatic lamps_t lamp_decode(state_e st);
        lamps_t l;
        l        = '0;
        l.ns_red = 1'b1;
        l.ew_red = 1'b1;
        case (st)
            StNsG:  begin l.ns_red = 1'b0; l.ns_green  = 1'b1; end
            StNsY:  begin l.ns_red = 1'b0; l.ns_yellow = 1'b1; end
            StEwG:  begin l.ew_red = 1'b0; l.ew_green  = 1'b1; end
            StEwY:  begin l.ew_red = 1'b0; l.ew_yellow = 1'b1; end
            StWalk: l.ped_walk = 1'b1;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter saturating at zero; counts remaining cycles in a phase.
module phase_timer #(
    parameter int unsigned     TW      = 4,
    parameter logic [TW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero,
    output logic [TW-1:0] count
);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero  = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/traffic_ctrl.sv
// Demand-actuated NS/EW traffic light controller with yellow, all-red clearance,
// pedestrian walk phase and latched vehicle/pedestrian requests.
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned T_GREEN  = 8,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_WALK   = 6,
    parameter int unsigned TW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ns_car,
    input  logic          ew_car,
    input  logic          ped_req,
    output logic          ns_green,
    output logic          ns_yellow,
    output logic          ns_red,
    output logic          ew_green,
    output logic          ew_yellow,
    output logic          ew_red,
    output logic          ped_walk,
    output logic [2:0]    phase,
    output logic [TW-1:0] timer
);

    localparam logic [TW-1:0] LdGreen  = TW'(T_GREEN - 1);
    localparam logic [TW-1:0] LdYellow = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] LdAllred = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] LdWalk   = TW'(T_WALK - 1);

    state_e        state_q, state_d;
    dir_e          next_dir_q, next_dir_d;
    logic          ns_pend_q, ns_pend_d;
    logic          ew_pend_q, ew_pend_d;
    logic          ped_pend_q, ped_pend_d;
    logic          entering;
    logic          t_zero;
    logic [TW-1:0] t_count;
    logic [TW-1:0] load_val;
    logic          ped_any;
    lamps_t        lamps;

    assign ped_any = ped_pend_q | ped_req;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StNsG:  if (t_zero && (ew_pend_q | ew_car | ped_any)) state_d = StNsY;
            StNsY:  if (t_zero) state_d = StArNe;
            StArNe: if (t_zero) state_d = ped_any ? StWalk : StEwG;
            StEwG:  if (t_zero && (ns_pend_q | ns_car | ped_any)) state_d = StEwY;
            StEwY:  if (t_zero) state_d = StArEn;
            StArEn: if (t_zero) state_d = ped_any ? StWalk : StNsG;
            StWalk: if (t_zero) state_d = (next_dir_q == DirEw) ? StEwG : StNsG;
            default: state_d = StNsG;
        endcase
    end

    // Green extension stays in the same state, so it never reloads the timer.
    assign entering = (state_d != state_q);

    always_comb begin
        load_val = LdGreen;
        case (state_d)
            StNsY, StEwY:   load_val = LdYellow;
            StArNe, StArEn: load_val = LdAllred;
            StWalk:         load_val = LdWalk;
            default:        load_val = LdGreen;
        endcase
    end

    // Clear beats set: a request arriving on the entry edge is served by that phase.
    always_comb begin
        ns_pend_d  = (ns_pend_q | ns_car) & ~(entering && state_d == StNsG);
        ew_pend_d  = (ew_pend_q | ew_car) & ~(entering && state_d == StEwG);
        ped_pend_d = ped_any & ~(entering && state_d == StWalk);
        next_dir_d = next_dir_q;
        if (entering && state_d == StArNe) next_dir_d = DirEw;
        if (entering && state_d == StArEn) next_dir_d = DirNs;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StNsG;
            next_dir_q <= DirEw;
            ns_pend_q  <= 1'b0;
            ew_pend_q  <= 1'b0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            next_dir_q <= next_dir_d;
            ns_pend_q  <= ns_pend_d;
            ew_pend_q  <= ew_pend_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    phase_timer #(
        .TW      (TW),
        .RST_VAL (LdGreen)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (entering),
        .load_val (load_val),
        .zero     (t_zero),
        .count    (t_count)
    );

    assign lamps     = lamp_decode(state_q);
    assign ns_green  = lamps.ns_green;
    assign ns_yellow = lamps.ns_yellow;
    assign ns_red    = lamps.ns_red;
    assign ew_green  = lamps.ew_green;
    assign ew_yellow = lamps.ew_yellow;
    assign ew_red    = lamps.ew_red;
    assign ped_walk  = lamps.ped_walk;
    assign phase     = state_q;
    assign timer     = t_count;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Bench for traffic_ctrl: directed scenarios plus random demand, checked against a
// phase/elapsed-time reference model.
module tb_traffic_ctrl;

    localparam int TG  = 8;
    localparam int TY  = 3;
    localparam int TA  = 1;
    localparam int TWK = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ns_car = 1'b0, ew_car = 1'b0, ped_req = 1'b0;
    logic       ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, ped_walk;
    logic [2:0] phase;
    logic [3:0] timer;

    logic       s_ns_car = 1'b0, s_ew_car = 1'b1, s_ped_req = 1'b0;
    logic       s_ns_green, s_ns_yellow, s_ns_red, s_ew_green, s_ew_yellow, s_ew_red;
    logic       s_ped_walk;
    logic [2:0] s_phase;
    logic [0:0] s_timer;

    traffic_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .ns_car    (ns_car),
        .ew_car    (ew_car),
        .ped_req   (ped_req),
        .ns_green  (ns_green),
        .ns_yellow (ns_yellow),
        .ns_red    (ns_red),
        .ew_green  (ew_green),
        .ew_yellow (ew_yellow),
        .ew_red    (ew_red),
        .ped_walk  (ped_walk),
        .phase     (phase),
        .timer     (timer)
    );

    traffic_ctrl #(
        .T_GREEN  (1),
        .T_YELLOW (1),
        .T_ALLRED (1),
        .T_WALK   (1),
        .TW       (1)
    ) u_dut_min (
        .clk       (clk),
        .rst       (rst),
        .ns_car    (s_ns_car),
        .ew_car    (s_ew_car),
        .ped_req   (s_ped_req),
        .ns_green  (s_ns_green),
        .ns_yellow (s_ns_yellow),
        .ns_red    (s_ns_red),
        .ew_green  (s_ew_green),
        .ew_yellow (s_ew_yellow),
        .ew_red    (s_ew_red),
        .ped_walk  (s_ped_walk),
        .phase     (s_phase),
        .timer     (s_timer)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase id, cycles elapsed in it, request flags, return direction.
    int m_ph, m_el;
    bit m_nsp, m_ewp, m_pdp, m_nd_ew;
    int cyc;
    int prev_ph;
    int ph_log[0:63];

    function automatic int dur(input int ph);
        case (ph)
            0, 3:    return TG;
            1, 4:    return TY;
            2, 5:    return TA;
            6:       return TWK;
            default: return 1;
        endcase
    endfunction

    function automatic logic [6:0] exp_lamps(input int ph);
        bit nsg, nsy, ewg, ewy;
        nsg = (ph == 0);
        nsy = (ph == 1);
        ewg = (ph == 3);
        ewy = (ph == 4);
        return {nsg, nsy, !(nsg || nsy), ewg, ewy, !(ewg || ewy), ph == 6};
    endfunction

    task automatic model_reset();
        m_ph    = 0;
        m_el    = 0;
        m_nsp   = 0;
        m_ewp   = 0;
        m_pdp   = 0;
        m_nd_ew = 1;
        cyc     = 0;
        prev_ph = 0;
    endtask

    task automatic model_edge();
        bit done, ped;
        int nxt;
        done = (m_el >= dur(m_ph) - 1);
        ped  = m_pdp || ped_req;
        nxt  = m_ph;
        if (done) begin
            case (m_ph)
                0: if (m_ewp || ew_car || ped) nxt = 1;
                1: nxt = 2;
                2: nxt = ped ? 6 : 3;
                3: if (m_nsp || ns_car || ped) nxt = 4;
                4: nxt = 5;
                5: nxt = ped ? 6 : 0;
                default: nxt = m_nd_ew ? 3 : 0;
            endcase
        end
        m_nsp = (m_nsp || ns_car) && !(nxt != m_ph && nxt == 0);
        m_ewp = (m_ewp || ew_car) && !(nxt != m_ph && nxt == 3);
        m_pdp = ped && !(nxt != m_ph && nxt == 6);
        if (nxt != m_ph) begin
            if (nxt == 2) m_nd_ew = 1;
            if (nxt == 5) m_nd_ew = 0;
            m_el = 0;
        end else if (m_el < 1000) begin
            m_el++;
        end
        m_ph = nxt;
    endtask

    task automatic check_outputs(input string pre);
        int t;
        t = dur(m_ph) - 1 - m_el;
        if (t < 0) t = 0;
        check_val({pre, "_phase"}, 32'(phase), 32'(m_ph));
        check_val({pre, "_timer"}, 32'(timer), 32'(t));
        check_val({pre, "_lamps"},
                  32'({ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, ped_walk}),
                  32'(exp_lamps(m_ph)));
    endtask

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic step(input string pre);
        bit yg;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < 64) ph_log[cyc] = int'(phase);
        check_outputs(pre);
        check_val({pre, "_no_conflict"}, 32'(ns_red | ew_red), 32'd1);
        yg = (prev_ph == 1 || prev_ph == 4) && (phase == 3'd0 || phase == 3'd3);
        check_val({pre, "_yel_to_grn"}, 32'(yg), 32'd0);
        prev_ph = int'(phase);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must settle before the next edge.
    task automatic do_reset(input string pre);
        #2;
        rst = 1'b1;
        #1;
        check_val({pre, "_rst_phase"}, 32'(phase), 32'd0);
        check_val({pre, "_rst_timer"}, 32'(timer), 32'(TG - 1));
        check_val({pre, "_rst_lamps"},
                  32'({ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, ped_walk}),
                  32'(7'b1000010));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ph_log[0] = int'(phase);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_min[0:4];
        int guard;
        exp_min = '{0, 1, 2, 3, 3};

        @(negedge clk);
        do_reset("init");
        check_outputs("c0");
        check_val("min_phase_c0", 32'(s_phase), 32'(exp_min[0]));
        for (int k = 1; k <= 4; k++) begin
            step("idle");
            check_val($sformatf("min_phase_c%0d", k), 32'(s_phase), 32'(exp_min[k]));
            check_val($sformatf("min_timer_c%0d", k), 32'(s_timer), 32'd0);
        end

        // Idle: NS green forever.
        for (int k = 5; k < 50; k++) step("idle");
        check_val("idle_end_phase", 32'(phase), 32'd0);
        check_val("idle_end_timer", 32'(timer), 32'd0);

        // EW demand from cycle 0.
        do_reset("ew");
        ew_car = 1'b1;
        for (int k = 0; k < 22; k++) step("ew");
        check_val("ew_c7", 32'(ph_log[7]), 32'd0);
        check_val("ew_c8", 32'(ph_log[8]), 32'd1);
        check_val("ew_c11", 32'(ph_log[11]), 32'd2);
        check_val("ew_c12", 32'(ph_log[12]), 32'd3);
        check_val("ew_c21", 32'(ph_log[21]), 32'd3);
        ew_car = 1'b0;

        // Single-cycle pedestrian pulse at cycle 2.
        do_reset("ped");
        for (int k = 0; k < 22; k++) begin
            ped_req = (k == 2);
            step("ped");
        end
        ped_req = 1'b0;
        check_val("ped_c10", 32'(ph_log[10]), 32'd1);
        check_val("ped_c12", 32'(ph_log[12]), 32'd6);
        check_val("ped_c17", 32'(ph_log[17]), 32'd6);
        check_val("ped_c18", 32'(ph_log[18]), 32'd3);

        // Both approaches busy: strict alternation.
        do_reset("both");
        ns_car = 1'b1;
        ew_car = 1'b1;
        for (int k = 0; k < 40; k++) step("both");
        check_val("both_c20", 32'(ph_log[20]), 32'd4);
        check_val("both_c23", 32'(ph_log[23]), 32'd5);
        check_val("both_c24", 32'(ph_log[24]), 32'd0);
        check_val("both_c36", 32'(ph_log[36]), 32'd3);

        // Reset in the middle of EW yellow, then idle: latches must have been dropped.
        guard = 0;
        while (phase != 3'd4 && guard < 40) begin
            step("both");
            guard++;
        end
        check_val("reach_ew_y", 32'(phase), 32'd4);
        step("both");
        do_reset("mid_ewy");
        ns_car = 1'b0;
        ew_car = 1'b0;
        for (int k = 0; k < 12; k++) step("after_rst");
        check_val("after_rst_phase", 32'(phase), 32'd0);

        // Random demand with occasional asynchronous resets.
        for (int k = 0; k < 600; k++) begin
            ns_car  = ($urandom_range(0, 3) == 0);
            ew_car  = ($urandom_range(0, 3) == 0);
            ped_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) do_reset("rnd");
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
